tdm_demux4: RTL and testbench

- Receiving end of the 4-to-1 time-division link: the transmit side selects one of four channels onto a single line with a 2-bit select (s1,s0).
- This block takes that single stream, tracks the select slot with an internal counter aligned by a frame-sync marker, and routes each beat to one of four registered channel outputs.
- It presents all four channels together, with a one-cycle valid strobe, once a full frame has been collected.
- It sits directly after the link line in the datapath lab designs.

---
 rtl/tdm_demux4.sv | 91 +++++++++
 tb/tb_tdm_demux4.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux4.sv
// tdm_demux4: receive side of the 4-slot TDM link.
// Collects one beat per slot after a sync marker and presents the full frame.
module tdm_demux4 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             in_sync,
   input  logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] d0,
   output logic [WIDTH-1:0] d1,
   output logic [WIDTH-1:0] d2,
   output logic [WIDTH-1:0] d3,
   output logic             out_valid,
   output logic             frame_err,
   output logic [1:0]       slot
);

   typedef enum logic {IDLE, RECV} state_t;

   state_t           state;
   logic [WIDTH-1:0] s0;
   logic [WIDTH-1:0] s1;
   logic [WIDTH-1:0] s2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         slot      <= 2'd0;
         s0        <= '0;
         s1        <= '0;
         s2        <= '0;
         d0        <= '0;
         d1        <= '0;
         d2        <= '0;
         d3        <= '0;
         out_valid <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         frame_err <= 1'b0;
         unique case (state)
            IDLE: begin
               // beats without a sync marker are dropped until aligned
               if (in_valid && in_sync) begin
                  s0    <= in_data;
                  slot  <= 2'd1;
                  state <= RECV;
               end
            end
            RECV: begin
               if (in_valid && in_sync) begin
                  frame_err <= 1'b1;
                  s0        <= in_data;
                  s1        <= '0;
                  s2        <= '0;
                  slot      <= 2'd1;
               end else if (in_valid) begin
                  unique case (slot)
                     2'd1: begin
                        s1   <= in_data;
                        slot <= 2'd2;
                     end
                     2'd2: begin
                        s2   <= in_data;
                        slot <= 2'd3;
                     end
                     2'd3: begin
                        // whole frame lands on one edge
                        d0        <= s0;
                        d1        <= s1;
                        d2        <= s2;
                        d3        <= in_data;
                        out_valid <= 1'b1;
                        slot      <= 2'd0;
                        state     <= IDLE;
                     end
                     default: begin
                        slot  <= 2'd0;
                        state <= IDLE;
                     end
                  endcase
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed and random checks of tdm_demux4
// against a queue-based frame model.
module tb_tdm_demux4;

   localparam int W = 1;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_sync = 1'b0;
   logic [W-1:0] in_data = '0;
   logic [W-1:0] d0, d1, d2, d3;
   logic         out_valid, frame_err;
   logic [1:0]   slot;

   int checks = 0;
   int failures = 0;

   logic [W-1:0] q[$];
   logic [W-1:0] m_d[4];
   logic         m_ov, m_fe;

   always #5 clk = ~clk;

   tdm_demux4 #(.WIDTH(W)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_sync(in_sync),
      .in_data(in_data),
      .d0(d0),
      .d1(d1),
      .d2(d2),
      .d3(d3),
      .out_valid(out_valid),
      .frame_err(frame_err),
      .slot(slot)
   );

   function automatic logic [4*W+3:0] got_vec();
      return {d0, d1, d2, d3, out_valid, frame_err, slot};
   endfunction

   function automatic logic [4*W+3:0] exp_vec();
      return {m_d[0], m_d[1], m_d[2], m_d[3], m_ov, m_fe,
              2'(q.size())};
   endfunction

   task automatic model_reset();
      q.delete();
      for (int i = 0; i < 4; i++) m_d[i] = '0;
      m_ov = 1'b0;
      m_fe = 1'b0;
   endtask

   // one clock: apply beat, advance model, settle past the edge
   task automatic drive(input logic v, input logic s,
                        input logic [W-1:0] d);
      in_valid = v;
      in_sync  = s;
      in_data  = d;
      @(posedge clk);
      m_ov = 1'b0;
      m_fe = 1'b0;
      if (v && s) begin
         if (q.size() != 0) m_fe = 1'b1;
         q.delete();
         q.push_back(d);
      end else if (v && q.size() != 0) begin
         q.push_back(d);
         if (q.size() == 4) begin
            for (int i = 0; i < 4; i++) m_d[i] = q[i];
            m_ov = 1'b1;
            q.delete();
         end
      end
      #1;
      in_valid = 1'b0;
      in_sync  = 1'b0;
   endtask

   task automatic pulse_reset();
      #1 rst_n = 1'b0;
      #1 model_reset();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      drive(1, 1, 1);
      drive(1, 0, 1);
      drive(1, 0, 1);
      drive(1, 0, 1);
      #1 rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (got_vec() !== '0) begin
         failures++;
         $display("FAIL reset_async got=%h exp=0", got_vec());
      end
      rst_n = 1'b1;
   endtask

   task automatic test_nominal();
      logic [3:0] b = 4'b0110;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (slot !== 2'(i)) begin
            failures++;
            $display("FAIL nominal_slot%0d got=%0d exp=%0d", i, slot, i);
         end
         drive(1, i == 0, b[3-i]);
         checks++;
         if (got_vec() !== exp_vec() || out_valid !== (i == 3)) begin
            failures++;
            $display("FAIL nominal_beat%0d got=%h exp=%h",
                     i, got_vec(), exp_vec());
         end
      end
      checks++;
      if ({d0, d1, d2, d3, slot} !== 6'b0110_00) begin
         failures++;
         $display("FAIL nominal_frame got=%b exp=011000",
                  {d0, d1, d2, d3, slot});
      end
      drive(0, 0, 0);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL nominal_pulse_len got=%b exp=0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] seq[10] = '{3'b111, 3'b100, 3'b100, 3'b000, 3'b000,
                              3'b101, 3'b110, 3'b101, 3'b101, 3'b100};
      int ov_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         drive(seq[i][2], seq[i][1], seq[i][0]);
         if (out_valid) ov_cnt++;
         checks++;
         if (got_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL b2b_step%0d got=%h exp=%h",
                     i, got_vec(), exp_vec());
         end
         if (i == 5) begin
            checks++;
            if ({d0, d1, d2, d3} !== 4'b1001) begin
               failures++;
               $display("FAIL b2b_frame1 got=%b exp=1001",
                        {d0, d1, d2, d3});
            end
         end
      end
      checks++;
      if ({d0, d1, d2, d3} !== 4'b0110 || ov_cnt != 2) begin
         failures++;
         $display("FAIL b2b_frame2 got=%b/%0d exp=0110/2",
                  {d0, d1, d2, d3}, ov_cnt);
      end
   endtask

   task automatic test_early_sync();
      logic [1:0] seq[6] = '{2'b11, 2'b00, 2'b10, 2'b01, 2'b01, 2'b00};
      int ov_cnt = 0;
      int fe_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         drive(1, seq[i][1], seq[i][0]);
         if (out_valid) ov_cnt++;
         if (frame_err) fe_cnt++;
         checks++;
         if (got_vec() !== exp_vec() || frame_err !== (i == 2)) begin
            failures++;
            $display("FAIL early_step%0d got=%h exp=%h",
                     i, got_vec(), exp_vec());
         end
      end
      checks++;
      if ({d0, d1, d2, d3} !== 4'b0110 || ov_cnt != 1 || fe_cnt != 1) begin
         failures++;
         $display("FAIL early_result got=%b ov=%0d fe=%0d exp=0110 1 1",
                  {d0, d1, d2, d3}, ov_cnt, fe_cnt);
      end
   endtask

   task automatic test_unsynced();
      pulse_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, W'($urandom));
         checks++;
         if ({out_valid, frame_err, slot} !== 4'b0) begin
            failures++;
            $display("FAIL unsync_drop%0d got=%b exp=0000",
                     i, {out_valid, frame_err, slot});
         end
      end
      for (int i = 0; i < 4; i++) drive(1, i == 0, 1);
      checks++;
      if ({d0, d1, d2, d3, out_valid} !== 5'b11111) begin
         failures++;
         $display("FAIL unsync_frame got=%b exp=11111",
                  {d0, d1, d2, d3, out_valid});
      end
   endtask

   task automatic test_reset_mid();
      drive(1, 1, 1);
      drive(1, 0, 1);
      pulse_reset();
      drive(1, 0, 1);
      drive(1, 0, 0);
      checks++;
      if (got_vec() !== '0) begin
         failures++;
         $display("FAIL reset_mid got=%h exp=0", got_vec());
      end
   endtask

   task automatic test_random();
      int bad = 0;
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(3, 0) != 0, $urandom_range(3, 0) == 0,
               W'($urandom));
         if (got_vec() !== exp_vec()) begin
            bad++;
            if (bad <= 5)
               $display("FAIL random_step%0d got=%h exp=%h",
                        i, got_vec(), exp_vec());
         end
      end
      checks++;
      if (bad != 0) failures++;
   endtask

   initial begin
      model_reset();
      #12 rst_n = 1'b1;
      test_reset();
      test_nominal();
      test_back_to_back();
      test_early_sync();
      test_unsynced();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
